// File: rtl/hf_bus_decoder.sv
`timescale 1ns/1ps
// hf_bus_decoder: memory-map decoder and read-return mux between the HF-RISCV
// core and NSLV slaves. Address bits [31:28] pick the slave (lowest index wins
// on duplicate tags). Per-slave wait states stall the core, big-endian slaves
// get their byte lanes reversed, and unmapped accesses are reported.
//
// Core handshake: an access is offered by holding cpu_req_i with a stable
// address/we/wdata; it is accepted on the clock edge where a slave select is
// asserted and cpu_stall_o is low. Read data for an accepted access appears on
// cpu_rdata_o in the cycle after that edge. While in WAIT the latched slave
// stays selected regardless of what the core drives.
module hf_bus_decoder #(
  parameter int unsigned NSLV = 3,
  parameter logic [31:0] TAGS = 32'h0000_0E40,
  parameter logic [15:0] LAT  = 16'h0000,
  parameter logic [7:0]  SWAP = 8'h04
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  input  logic [3:0]           cpu_we_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic [NSLV-1:0]      s_sel_o,
  output logic [31:0]          s_addr_o,
  output logic [31:0]          s_wdata_o,
  output logic [3:0]           s_we_o,
  input  logic [32*NSLV-1:0]   s_rdata_i,
  output logic                 err_o,
  output logic [31:0]          err_addr_o,
  output logic [7:0]           err_cnt_o,
  output logic [1:0]           dbg_state_o
);

  localparam int unsigned IW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [IW-1:0]   wsel_q, wsel_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [31:0]     err_addr_q, err_addr_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic            hit_any;
  logic [IW-1:0]   hit_idx;
  logic            act;
  logic [IW-1:0]   act_idx;
  logic            act_swap;
  logic            stall;
  logic            fire;
  logic [31:0]     rsel_word;
  logic            rsel_swap;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [1:0] lat_of(input logic [IW-1:0] idx);
    logic [1:0] r;
    r = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (idx == IW'(k)) r = LAT[2*k +: 2];
    end
    return r;
  endfunction

  // Address decode: scan from the top so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (cpu_req_i && (cpu_addr_i[31:28] == TAGS[4*k +: 4])) begin
        hit_any = 1'b1;
        hit_idx = IW'(k);
      end
    end
  end

  // Next-state logic: wait-state sequencing, error capture, read-return latch.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    wsel_d     = wsel_q;
    sel_d      = sel_q;
    valid_d    = valid_q;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    act        = 1'b0;
    act_idx    = hit_idx;
    stall      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hit_any) begin
          act = 1'b1;
          if (lat_of(hit_idx) != 2'd0) begin
            stall   = 1'b1;
            state_d = S_WAIT;
            wcnt_d  = lat_of(hit_idx) - 2'd1;
            wsel_d  = hit_idx;
          end
        end else if (cpu_req_i) begin
          state_d    = S_ERR;
          err_addr_d = cpu_addr_i;
          valid_d    = 1'b0;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      S_WAIT: begin
        act     = 1'b1;
        act_idx = wsel_q;
        if (wcnt_q != 2'd0) begin
          stall  = 1'b1;
          wcnt_d = wcnt_q - 2'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    fire = act && !stall;
    if (fire) begin
      sel_d   = act_idx;
      valid_d = 1'b1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      wsel_q     <= '0;
      sel_q      <= '0;
      valid_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wsel_q     <= wsel_d;
      sel_q      <= sel_d;
      valid_q    <= valid_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Slave-side select and write lane swap; all memories enabled during reset.
  always_comb begin
    s_sel_o  = '0;
    act_swap = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      s_sel_o[k] = act && (act_idx == IW'(k));
      if (act && (act_idx == IW'(k))) act_swap = SWAP[k];
    end
    if (reset) s_sel_o = '1;
  end

  // Read-return mux for the last accepted access, swapped for big-endian slaves.
  always_comb begin
    rsel_word = '0;
    rsel_swap = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (sel_q == IW'(k)) begin
        rsel_word = s_rdata_i[32*k +: 32];
        rsel_swap = SWAP[k];
      end
    end
    if (!valid_q)       cpu_rdata_o = '0;
    else if (rsel_swap) cpu_rdata_o = bswap(rsel_word);
    else                cpu_rdata_o = rsel_word;
  end

  assign s_addr_o    = cpu_addr_i;
  assign s_wdata_o   = act_swap ? bswap(cpu_wdata_i) : cpu_wdata_i;
  assign s_we_o      = (fire && !reset) ? cpu_we_i : 4'h0;
  assign cpu_stall_o = stall && !reset;
  assign err_o       = (state_q == S_ERR);
  assign err_addr_o  = err_addr_q;
  assign err_cnt_o   = err_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hf_bus_decoder.sv
`timescale 1ns/1ps
// Testbench for hf_bus_decoder: six slaves (boot, RAM, swapped periph, a
// 2-wait-state slave, a 3-wait-state swapped slave, and a duplicate RAM tag
// that must lose to the lower index). A transaction-level model tracks what
// each output must be; compare_all checks it every cycle.
module tb_hf_bus_decoder;

  localparam int NS = 6;

  logic               clock;
  logic               reset;
  logic               cpu_req_i;
  logic [31:0]        cpu_addr_i;
  logic [31:0]        cpu_wdata_i;
  logic [3:0]         cpu_we_i;
  logic [31:0]        cpu_rdata_o;
  logic               cpu_stall_o;
  logic [NS-1:0]      s_sel_o;
  logic [31:0]        s_addr_o;
  logic [31:0]        s_wdata_o;
  logic [3:0]         s_we_o;
  logic [32*NS-1:0]   s_rdata_i;
  logic               err_o;
  logic [31:0]        err_addr_o;
  logic [7:0]         err_cnt_o;
  logic [1:0]         dbg_state_o;

  hf_bus_decoder #(
    .NSLV (NS),
    .TAGS (32'h0046_5E40),
    .LAT  (16'h0380),
    .SWAP (8'h14)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpu_req_i   (cpu_req_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .s_sel_o     (s_sel_o),
    .s_addr_o    (s_addr_o),
    .s_wdata_o   (s_wdata_o),
    .s_we_o      (s_we_o),
    .s_rdata_i   (s_rdata_i),
    .err_o       (err_o),
    .err_addr_o  (err_addr_o),
    .err_cnt_o   (err_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  // Memory map of the bench, written independently of the packed parameters.
  int          tag_tab[NS]  = '{0, 4, 14, 5, 6, 4};
  int          lat_tab[NS]  = '{0, 0, 0, 2, 3, 0};
  bit          swap_tab[NS] = '{0, 0, 1, 0, 1, 0};
  logic [31:0] data_tab[NS] = '{32'h1122_3344, 32'hA1B2_C3D4, 32'h0102_0304,
                                32'h5A5A_0001, 32'hCAFE_F00D, 32'hDEAD_BEEF};
  int          unm_tab[11]  = '{1, 2, 3, 7, 8, 9, 10, 11, 12, 13, 15};

  // Model state.
  int          exp_tgt;
  bit          exp_stall;
  bit          exp_err;
  int          last_slave;
  logic [31:0] m_err_addr;
  int          m_err_cnt;

  // Counters and captures.
  int          n_cmp;
  int          n_bad;
  int          n_stall;
  int          n_we;
  int          n_errp;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_we;
  logic [NS-1:0] cap_sel;
  int          base;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++) begin
      if (int'(a[31:28]) == tag_tab[k]) return k;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic compare_all();
    logic [NS-1:0] e_sel;
    logic [31:0]   e_wd;
    logic [31:0]   e_rd;
    logic [3:0]    e_we;
    if (reset) begin
      check("sel_in_reset",   32'(s_sel_o),     32'h3F);
      check("we_in_reset",    32'(s_we_o),      32'h0);
      check("stall_in_reset", 32'(cpu_stall_o), 32'h0);
      check("rdata_in_reset", cpu_rdata_o,      32'h0);
      check("err_in_reset",   32'(err_o),       32'h0);
      check("eaddr_in_reset", err_addr_o,       32'h0);
      check("ecnt_in_reset",  32'(err_cnt_o),   32'h0);
    end else begin
      e_sel = '0;
      e_wd  = cpu_wdata_i;
      e_we  = 4'h0;
      if (exp_tgt >= 0) begin
        e_sel[exp_tgt] = 1'b1;
        if (swap_tab[exp_tgt]) e_wd = bswap(cpu_wdata_i);
        if (!exp_stall) e_we = cpu_we_i;
      end
      if (last_slave < 0)              e_rd = 32'h0;
      else if (swap_tab[last_slave])   e_rd = bswap(data_tab[last_slave]);
      else                             e_rd = data_tab[last_slave];
      check("sel",   32'(s_sel_o),     32'(e_sel));
      check("stall", 32'(cpu_stall_o), 32'(exp_stall));
      check("we",    32'(s_we_o),      32'(e_we));
      check("wdata", s_wdata_o,        e_wd);
      check("addr",  s_addr_o,         cpu_addr_i);
      check("rdata", cpu_rdata_o,      e_rd);
      check("err",   32'(err_o),       32'(exp_err));
      check("eaddr", err_addr_o,       m_err_addr);
      check("ecnt",  32'(err_cnt_o),   32'(m_err_cnt));
      if (cpu_stall_o) n_stall++;
      if (err_o) n_errp++;
      if (s_sel_o != '0) cap_sel = s_sel_o;
      if (s_we_o != 4'h0) begin
        n_we++;
        cap_we    = s_we_o;
        cap_wdata = s_wdata_o;
      end
    end
  endtask

  // Compare at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clock);
    compare_all();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    cpu_req_i = 1'b0;
    cpu_we_i  = 4'h0;
    cpu_addr_i = 32'h0;
    exp_tgt   = -1;
    exp_stall = 1'b0;
  endtask

  // One core access, holding the request through any stall cycles. Middle
  // stall cycles drive an unrelated, unmapped address with req low, which the
  // decoder must ignore while it waits.
  task automatic access(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    int tgt;
    int lat;
    tgt = decode(addr);
    cpu_wdata_i = wd;
    if (tgt < 0) begin
      cpu_req_i = 1'b1; cpu_addr_i = addr; cpu_we_i = we;
      exp_tgt = -1; exp_stall = 1'b0; exp_err = 1'b0;
      step();
      m_err_addr = addr;
      if (m_err_cnt < 255) m_err_cnt++;
      last_slave = -1;
      drive_idle();
      exp_err = 1'b1;
      step();
      exp_err = 1'b0;
    end else begin
      lat = lat_tab[tgt];
      for (int c = 0; c <= lat; c++) begin
        cpu_we_i = we;
        if (c > 0 && c < lat) begin
          cpu_req_i  = 1'b0;
          cpu_addr_i = 32'h8000_0000 + 32'(c);
        end else begin
          cpu_req_i  = 1'b1;
          cpu_addr_i = addr;
        end
        exp_tgt   = tgt;
        exp_stall = (c < lat);
        step();
      end
      last_slave = tgt;
    end
    drive_idle();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; n_stall = 0; n_we = 0; n_errp = 0;
    cap_wdata = '0; cap_we = '0; cap_sel = '0; base = 0;
    exp_tgt = -1; exp_stall = 1'b0; exp_err = 1'b0;
    last_slave = -1; m_err_addr = '0; m_err_cnt = 0;
    for (int k = 0; k < NS; k++) s_rdata_i[32*k +: 32] = data_tab[k];
    cpu_wdata_i = '0;
    drive_idle();
    reset = 1'b1;
    step();
    step();
    #1 reset = 1'b0;
    check("state_after_reset", 32'(dbg_state_o), 32'h0);
    step();

    // Boot read, no wait states.
    base = n_stall;
    access(32'h0000_0010, 4'h0, 32'h0);
    check("boot_rdata", cpu_rdata_o, 32'h1122_3344);
    check("boot_no_stall", 32'(n_stall - base), 32'h0);
    step();

    // Write to swapped peripheral.
    base = n_we;
    access(32'hE000_0004, 4'hF, 32'hAABB_CCDD);
    check("periph_we_pulses", 32'(n_we - base), 32'h1);
    check("periph_wdata", cap_wdata, 32'hDDCC_BBAA);
    check("periph_we", 32'(cap_we), 32'hF);
    check("periph_sel", 32'(cap_sel), 32'h04);
    step();

    // Two-wait-state read and write.
    base = n_stall;
    access(32'h5000_0000, 4'h0, 32'h0);
    check("lat2_stall_cycles", 32'(n_stall - base), 32'h2);
    check("lat2_rdata", cpu_rdata_o, 32'h5A5A_0001);
    base = n_we;
    access(32'h5000_0008, 4'h3, 32'h0BAD_F00D);
    check("lat2_we_pulses", 32'(n_we - base), 32'h1);
    check("lat2_we", 32'(cap_we), 32'h3);
    step();

    // Three-wait-state swapped slave.
    base = n_stall;
    access(32'h6000_0000, 4'h0, 32'h0);
    check("lat3_stall_cycles", 32'(n_stall - base), 32'h3);
    check("lat3_rdata", cpu_rdata_o, 32'h0DF0_FECA);
    step();

    // Duplicate tag: lower index must win.
    access(32'h4000_0020, 4'h0, 32'h0);
    check("prio_sel", 32'(cap_sel), 32'h02);
    check("prio_rdata", cpu_rdata_o, 32'hA1B2_C3D4);
    step();

    // Unmapped access.
    base = n_errp;
    access(32'h8000_0000, 4'h0, 32'h0);
    check("err_pulses", 32'(n_errp - base), 32'h1);
    check("err_addr", err_addr_o, 32'h8000_0000);
    check("err_cnt", 32'(err_cnt_o), 32'h1);
    check("err_rdata", cpu_rdata_o, 32'h0);
    step();

    // Back-to-back alternating reads with no wait states.
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       access(32'h0000_0100, 4'h0, 32'h0);
        1:       access(32'h4000_0200, 4'h0, 32'h0);
        default: access(32'hE000_0300, 4'h0, 32'h0);
      endcase
    end
    check("alt_last_rdata", cpu_rdata_o, 32'h0403_0201);
    step();

    // Saturate the error counter.
    for (int i = 0; i < 300; i++) begin
      access({4'(unm_tab[i % 11]), 28'(i * 4)}, 4'h0, 32'h0);
    end
    check("err_cnt_saturated", 32'(err_cnt_o), 32'hFF);
    check("err_addr_last", err_addr_o, 32'h3000_04AC);
    step();

    // Reset in the middle of a three-wait-state write.
    cpu_req_i = 1'b1; cpu_addr_i = 32'h6000_0000; cpu_we_i = 4'hF;
    cpu_wdata_i = 32'h1234_5678;
    exp_tgt = 4; exp_stall = 1'b1;
    step();
    check("stall_before_reset", 32'(cpu_stall_o), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("stall_drops_async", 32'(cpu_stall_o), 32'h0);
    check("sel_all_async", 32'(s_sel_o), 32'h3F);
    check("we_dropped_async", 32'(s_we_o), 32'h0);
    last_slave = -1; m_err_cnt = 0; m_err_addr = '0; exp_err = 1'b0;
    drive_idle();
    step();
    step();
    #1 reset = 1'b0;
    check("state_idle_post", 32'(dbg_state_o), 32'h0);
    check("rdata_post", cpu_rdata_o, 32'h0);
    check("ecnt_post", 32'(err_cnt_o), 32'h0);
    check("eaddr_post", err_addr_o, 32'h0);
    check("stall_post", 32'(cpu_stall_o), 32'h0);
    step();

    access(32'h0000_0010, 4'h0, 32'h0);
    check("boot_rdata_post", cpu_rdata_o, 32'h1122_3344);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hf_bus_decoder.md
Name: hf_bus_decoder

Overview:
- Parametrised memory-map decoder and read-return mux between the HF-RISCV core and N slaves (boot ROM, RAM, peripherals, ...).
- Selects a slave from address bits [31:28] and returns its read data one cycle later, or later for slaves with wait states.
- Inserts per-slave wait states by stalling the core and byte-swaps data lanes for big-endian slaves.
- Reports accesses to unmapped regions through an error pulse, a captured address and a saturating error counter.

Parameters:
- NSLV, 3, number of slaves (1..8).
- TAGS, 32'h0000_0E40, 4-bit address[31:28] tag per slave, packed; slave k uses TAGS[4k+3:4k]. Default: s0=0x0 boot, s1=0x4 RAM, s2=0xE periph.
- LAT, 16'h0000, 2-bit wait-state count per slave, packed; slave k uses LAT[2k+1:2k], values 0..3.
- SWAP, 8'h04, per-slave bit; 1 = reverse the byte lanes of read and write data for that slave.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: reset, asynchronous, active-high.
- cpu_req_i, in, 1: core presents a valid access this cycle.
- cpu_addr_i, in, 32: core address.
- cpu_wdata_i, in, 32: core write data.
- cpu_we_i, in, 4: core byte write enables; 0000 = read.
- cpu_rdata_o, out, 32: read data to the core.
- cpu_stall_o, out, 1: stall to the core.
- s_sel_o, out, NSLV: one-hot slave select, active-high.
- s_addr_o, out, 32: address to the slaves, equal to cpu_addr_i.
- s_wdata_o, out, 32: write data to the slaves, swapped per SWAP of the selected slave.
- s_we_o, out, 4: byte write enables to the slaves; 0 unless a slave is selected.
- s_rdata_i, in, 32*NSLV: flattened read data; slave k occupies [32k+31:32k].
- err_o, out, 1: one-cycle pulse on an unmapped access.
- err_addr_o, out, 32: address of the most recent unmapped access.
- err_cnt_o, out, 8: saturating count of unmapped accesses.

Behaviour:
- Decode (combinational): hit[k] = cpu_req_i && cpu_addr_i[31:28]==TAG_k. If several tags match, the lowest index wins. s_sel_o is the one-hot of the winner.
- While reset is high: s_sel_o = all ones, matching the boot-time enable of all memories. s_we_o=0.
- FSM states:
  - IDLE: request to slave k with LAT_k=0 → stay in IDLE, stall_o=0. Request with LAT_k>0 → WAIT, wcnt=LAT_k-1, stall_o=1 in this cycle. Unmapped request → ERR.
  - WAIT: s_sel_o holds the slave latched at entry and ignores cpu_addr_i and cpu_req_i changes. stall_o=1 while wcnt!=0; wcnt decrements each clock. The cycle with wcnt==0 has stall_o=0 and returns to IDLE. Total stall cycles = LAT_k.
  - ERR: a single cycle. err_o=1, stall_o=0, no select asserted, then IDLE. err_addr_o and err_cnt_o are updated on the clock edge entering ERR; err_cnt_o saturates at 0xFF.
- Read return:
  - sel_q (slave index) and valid_q are registered on every clock edge at which a select is asserted and stall_o=0.
  - The cycle after that edge: cpu_rdata_o = s_rdata_i[sel_q], swapped if SWAP[sel_q].
  - Read latency is 1 cycle after the last stall cycle, the same as a synchronous BRAM.
  - When valid_q=0 or the previous access was unmapped: cpu_rdata_o = 0.
- Writes: s_we_o = cpu_we_i only in the cycle where a select is asserted and stall_o=0. This gives exactly one write strobe per access, including wait-state slaves.
- Byte swap: the word is {b[7:0], b[15:8], b[23:16], b[31:24]}; it applies symmetrically to wdata and rdata.
- Back-to-back accesses to different slaves with LAT=0: each returns its own slave's data with no bubble.
- Reset values: state=IDLE, wcnt=0, sel_q=0, valid_q=0, cpu_stall_o=0, cpu_rdata_o=0, err_o=0, err_addr_o=0, err_cnt_o=0.
- Reset asserted mid-WAIT: stall drops immediately (asynchronous) and any pending write is discarded.

Test Plan:
- Read boot (0x00000010, s0 returns 0x11223344, LAT=0) → stall never asserted; cpu_rdata_o=0x11223344 one cycle after the request.
- Write 0xAABBCCDD to periph 0xE0000004 with we=1111 (SWAP s2) → s_wdata_o=0xDDCCBBAA, s_we_o=1111 for one cycle, s_sel_o=100.
- Set LAT s1=2; read RAM 0x40000000 (data 0x5A5A0001) → stall_o high exactly 2 cycles; data valid the cycle after stall falls; a write request gives exactly one s_we_o pulse.
- Access 0x80000000 → err_o one-cycle pulse, err_addr_o=0x80000000, err_cnt_o +1, cpu_rdata_o=0. 300 unmapped accesses → err_cnt_o=0xFF.
- Alternate reads s0/s1/s2 each cycle (LAT=0) → cpu_rdata_o tracks the correct slave every cycle; s2 data is byte-swapped.
- Assert reset during a WAIT with LAT=3 → stall_o=0 in the same cycle; after release, state IDLE and all outputs at reset values.
